// File: rtl/mutual_rule_scheduler.sv
// Round-robin rule scheduler for the mutual-exclusion `system` model: issues one
// enable pulse per step to a fireable node and checks the mutex invariant after each step.
module mutual_rule_scheduler #(
    parameter int unsigned N     = 3,
    parameter int unsigned CNT_W = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [CNT_W-1:0]   step_limit,
    input  logic [2*N-1:0]     n_state,
    input  logic               x_flag,
    output logic [N-1:0]       io_en_a,
    output logic               busy,
    output logic               done,
    output logic               deadlock,
    output logic               mutex_err,
    output logic [CNT_W-1:0]   step_count
);

    localparam int unsigned PTR_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [1:0]  ST_T  = 2'd1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_ISSUE,
        S_CHECK,
        S_FINISH,
        S_HALT
    } state_t;

    state_t             r_state, w_state;
    logic [PTR_W-1:0]   r_ptr, w_ptr;
    logic [PTR_W-1:0]   r_sel, w_sel;
    logic [CNT_W-1:0]   r_limit, w_limit;
    logic [CNT_W-1:0]   r_count, w_count;
    logic [N-1:0]       r_en, w_en;
    logic               r_busy, w_busy;
    logic               r_done, w_done;
    logic               r_deadlock, w_deadlock;
    logic               r_mutex_err, w_mutex_err;

    logic [N-1:0]       w_fire;
    logic               w_ce_any;
    logic               w_ce_many;
    logic               w_found;
    logic [PTR_W-1:0]   w_k;
    logic [PTR_W-1:0]   w_ptr_inc;

    // Node i may fire unless it is trying (T) while x is clear.
    always_comb begin
        w_fire = '0;
        for (int unsigned i = 0; i < N; i++) begin
            w_fire[i] = (n_state[2*i +: 2] != ST_T) || x_flag;
        end
    end

    // Count of nodes in C or E (upper encoding bit set), saturated at "two or more".
    always_comb begin
        w_ce_any  = 1'b0;
        w_ce_many = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (n_state[2*i+1]) begin
                if (w_ce_any) begin
                    w_ce_many = 1'b1;
                end
                w_ce_any = 1'b1;
            end
        end
    end

    // First fireable node at or after the pointer, wrapping mod N.
    always_comb begin
        int unsigned v_idx;
        w_found = 1'b0;
        w_k     = '0;
        v_idx   = 0;
        for (int unsigned j = 0; j < N; j++) begin
            v_idx = 32'(r_ptr) + j;
            if (v_idx >= N) begin
                v_idx = v_idx - N;
            end
            if (!w_found && w_fire[PTR_W'(v_idx)]) begin
                w_found = 1'b1;
                w_k     = PTR_W'(v_idx);
            end
        end
    end

    assign w_ptr_inc = ((32'(r_sel) + 32'd1) >= N) ? '0 : PTR_W'(32'(r_sel) + 32'd1);

    // Next-state and registered-output logic.
    always_comb begin
        w_state     = r_state;
        w_ptr       = r_ptr;
        w_sel       = r_sel;
        w_limit     = r_limit;
        w_count     = r_count;
        w_en        = '0;
        w_deadlock  = r_deadlock;
        w_mutex_err = r_mutex_err;

        case (r_state)
            S_IDLE, S_HALT: begin
                if (start) begin
                    w_limit     = step_limit;
                    w_count     = '0;
                    w_deadlock  = 1'b0;
                    w_mutex_err = 1'b0;
                    w_state     = (step_limit == '0) ? S_FINISH : S_SELECT;
                end
            end
            S_SELECT: begin
                if (w_found) begin
                    w_en    = N'(1) << w_k;
                    w_sel   = w_k;
                    w_state = S_ISSUE;
                end else begin
                    w_deadlock = 1'b1;
                    w_state    = S_HALT;
                end
            end
            S_ISSUE: begin
                w_ptr = w_ptr_inc;
                if (r_count != '1) begin
                    w_count = r_count + CNT_W'(1);
                end
                w_state = S_CHECK;
            end
            S_CHECK: begin
                if (w_ce_many || (w_ce_any && x_flag)) begin
                    w_mutex_err = 1'b1;
                    w_state     = S_HALT;
                end else if ((r_count == r_limit) || (r_count == '1)) begin
                    w_state = S_FINISH;
                end else begin
                    w_state = S_SELECT;
                end
            end
            S_FINISH: begin
                w_state = S_IDLE;
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase

        w_done = (w_state == S_FINISH);
        w_busy = (w_state == S_SELECT) || (w_state == S_ISSUE) ||
                 (w_state == S_CHECK)  || (w_state == S_FINISH);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_ptr       <= '0;
            r_sel       <= '0;
            r_limit     <= '0;
            r_count     <= '0;
            r_en        <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_deadlock  <= 1'b0;
            r_mutex_err <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_ptr       <= w_ptr;
            r_sel       <= w_sel;
            r_limit     <= w_limit;
            r_count     <= w_count;
            r_en        <= w_en;
            r_busy      <= w_busy;
            r_done      <= w_done;
            r_deadlock  <= w_deadlock;
            r_mutex_err <= w_mutex_err;
        end
    end

    assign io_en_a    = r_en;
    assign busy       = r_busy;
    assign done       = r_done;
    assign deadlock   = r_deadlock;
    assign mutex_err  = r_mutex_err;
    assign step_count = r_count;

endmodule

// File: tb/tb_mutual_rule_scheduler.sv
// Directed bench for mutual_rule_scheduler: node states are driven directly and
// every pulse, done and flag is compared with hand-derived values.
module tb_mutual_rule_scheduler;

    localparam int unsigned N     = 3;
    localparam int unsigned CNT_W = 16;

    localparam logic [5:0] ALL_I  = 6'b00_00_00;
    localparam logic [5:0] ALL_T  = 6'b01_01_01;
    localparam logic [5:0] SKIP_V = 6'b00_01_01;  // node2=I, node1=T, node0=T
    localparam logic [5:0] BAD_V  = 6'b00_11_10;  // node1=E, node0=C

    logic             clock;
    logic             reset;
    logic             start;
    logic [CNT_W-1:0] step_limit;
    logic [2*N-1:0]   n_state;
    logic             x_flag;
    logic [N-1:0]     io_en_a;
    logic             busy;
    logic             done;
    logic             deadlock;
    logic             mutex_err;
    logic [CNT_W-1:0] step_count;

    int n_cmp;
    int n_err;

    logic [N-1:0] p_val [16];
    int           p_cyc [16];
    int           n_p;
    int           n_done;

    mutual_rule_scheduler #(.N(N), .CNT_W(CNT_W)) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .step_limit (step_limit),
        .n_state    (n_state),
        .x_flag     (x_flag),
        .io_en_a    (io_en_a),
        .busy       (busy),
        .done       (done),
        .deadlock   (deadlock),
        .mutex_err  (mutex_err),
        .step_count (step_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
    endtask

    // Start sampled on the following posedge; returns on the negedge after it.
    task automatic do_start(input int lim);
        @(negedge clock);
        start      = 1'b1;
        step_limit = CNT_W'(lim);
        @(negedge clock);
        start      = 1'b0;
    endtask

    // Records pulses and done over a window; optionally injects a stray start at cycle inj.
    task automatic collect(input int cycles, input int inj);
        n_p    = 0;
        n_done = 0;
        for (int c = 0; c < cycles; c++) begin
            if (io_en_a != '0) begin
                if (n_p < 16) begin
                    p_val[n_p] = io_en_a;
                    p_cyc[n_p] = c;
                end
                n_p++;
            end
            if (done) n_done++;
            if (c == inj) begin
                start      = 1'b1;
                step_limit = CNT_W'(7);
            end else begin
                start = 1'b0;
            end
            @(negedge clock);
        end
        start = 1'b0;
    endtask

    // Waits (bounded) for the n-th pulse; leaves the bench on the negedge inside ISSUE.
    task automatic wait_pulse(input string tag, input int nth, output logic [N-1:0] val);
        int seen;
        seen = 0;
        val  = '0;
        for (int c = 0; c < 40; c++) begin
            if (io_en_a != '0) begin
                seen++;
                if (seen == nth) begin
                    val = io_en_a;
                    return;
                end
            end
            @(negedge clock);
        end
        chk(tag, 32'(seen), 32'(nth));
    endtask

    initial begin
        logic [N-1:0] v;
        n_cmp      = 0;
        n_err      = 0;
        reset      = 1'b0;
        start      = 1'b0;
        step_limit = '0;
        n_state    = ALL_I;
        x_flag     = 1'b1;
        do_reset();

        chk("rst_en",    32'(io_en_a),    32'h0);
        chk("rst_busy",  32'(busy),       32'h0);
        chk("rst_done",  32'(done),       32'h0);
        chk("rst_dl",    32'(deadlock),   32'h0);
        chk("rst_merr",  32'(mutex_err),  32'h0);
        chk("rst_cnt",   32'(step_count), 32'h0);

        // Normal run of 5 on an all-idle model.
        do_start(5);
        chk("run_busy", 32'(busy), 32'h1);
        collect(25, -1);
        chk("run_np",   32'(n_p), 32'd5);
        chk("run_p0",   32'(p_val[0]), 32'b001);
        chk("run_p1",   32'(p_val[1]), 32'b010);
        chk("run_p2",   32'(p_val[2]), 32'b100);
        chk("run_p3",   32'(p_val[3]), 32'b001);
        chk("run_p4",   32'(p_val[4]), 32'b010);
        chk("run_c0",   32'(p_cyc[0]), 32'd1);
        for (int i = 1; i < 5; i++) begin
            chk("run_gap", 32'(p_cyc[i] - p_cyc[i-1]), 32'd3);
        end
        chk("run_done", 32'(n_done), 32'd1);
        chk("run_cnt",  32'(step_count), 32'd5);
        chk("run_merr", 32'(mutex_err), 32'h0);
        chk("run_idle", 32'(busy), 32'h0);

        // Skip unfireable trying nodes from ptr=0.
        do_reset();
        n_state = SKIP_V;
        x_flag  = 1'b0;
        do_start(1);
        collect(10, -1);
        chk("skip_np",   32'(n_p), 32'd1);
        chk("skip_p0",   32'(p_val[0]), 32'b100);
        chk("skip_done", 32'(n_done), 32'd1);
        n_state = ALL_I;
        x_flag  = 1'b1;
        do_start(1);
        collect(10, -1);
        chk("skip_ptr0", 32'(p_val[0]), 32'b001);

        // Deadlock: every node trying with x clear.
        n_state = ALL_T;
        x_flag  = 1'b0;
        do_start(4);
        collect(10, -1);
        chk("dl_flag", 32'(deadlock), 32'h1);
        chk("dl_busy", 32'(busy), 32'h0);
        chk("dl_np",   32'(n_p), 32'd0);
        chk("dl_done", 32'(n_done), 32'd0);
        chk("dl_cnt",  32'(step_count), 32'd0);

        // Invariant violation injected after the first pulse (restart from HALT).
        n_state = ALL_I;
        x_flag  = 1'b1;
        do_start(5);
        chk("inv_dlclr", 32'(deadlock), 32'h0);
        wait_pulse("inv_wait", 1, v);
        chk("inv_p0", 32'(v), 32'b010);
        n_state = BAD_V;
        @(negedge clock);
        chk("inv_chk_merr", 32'(mutex_err), 32'h0);
        @(negedge clock);
        chk("inv_merr", 32'(mutex_err), 32'h1);
        chk("inv_busy", 32'(busy), 32'h0);
        collect(10, -1);
        chk("inv_np",   32'(n_p), 32'd0);
        chk("inv_done", 32'(n_done), 32'd0);
        chk("inv_cnt",  32'(step_count), 32'd1);

        // Zero limit: done one cycle after start, no pulses.
        n_state = ALL_I;
        do_start(0);
        chk("zl_done", 32'(done), 32'h1);
        chk("zl_merr", 32'(mutex_err), 32'h0);
        collect(6, -1);
        chk("zl_np",   32'(n_p), 32'd0);
        chk("zl_busy", 32'(busy), 32'h0);

        // Reset during the third ISSUE of a run of 10.
        do_start(10);
        wait_pulse("mr_wait", 3, v);
        chk("mr_p2", 32'(v), 32'b010);
        reset = 1'b0;
        #1;
        chk("mr_en",   32'(io_en_a),    32'h0);
        chk("mr_busy", 32'(busy),       32'h0);
        chk("mr_done", 32'(done),       32'h0);
        chk("mr_cnt",  32'(step_count), 32'h0);
        chk("mr_dl",   32'(deadlock),   32'h0);
        chk("mr_merr", 32'(mutex_err),  32'h0);
        @(negedge clock);
        reset = 1'b1;
        do_start(1);
        collect(10, -1);
        chk("mr_ptr0", 32'(p_val[0]), 32'b001);

        // Second start while busy is ignored.
        do_start(2);
        collect(20, 1);
        chk("ign_np",   32'(n_p), 32'd2);
        chk("ign_p0",   32'(p_val[0]), 32'b010);
        chk("ign_p1",   32'(p_val[1]), 32'b100);
        chk("ign_done", 32'(n_done), 32'd1);
        chk("ign_cnt",  32'(step_count), 32'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mutual_rule_scheduler.md
Name: mutual_rule_scheduler

Overview:
- Drives the rule-enable vector (io_en_a) of the generated mutual-exclusion `system` model. It is the active end of that interface; today a testbench plays this role with hand-written stimulus.
- Picks one fireable node per step, round-robin, and issues a one-cycle enable pulse.
- Watches the returned node states and x flag, and checks the mutual-exclusion invariant after every step.
- Used in simulation harnesses and in formal wrappers to generate fair traces.

Parameters:
- N, 3, number of nodes; width of io_en_a.
- CNT_W, 16, width of the step counter and step limit.

Ports:
- clock  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse; begins a run while IDLE, ignored otherwise.
- step_limit  input  CNT_W  number of enable pulses in a run; sampled at start.
- n_state  input  2*N  node states; node i is in bits [2i+1:2i]. Encoding: I=0, T=1, C=2, E=3.
- x_flag  input  1  shared x register of the model.
- io_en_a  output  N  rule-enable vector to the model; one-hot or zero.
- busy  output  1  high while a run is in progress.
- done  output  1  one-cycle pulse when a run ends normally.
- deadlock  output  1  sticky; no node was fireable.
- mutex_err  output  1  sticky; invariant violated.
- step_count  output  CNT_W  pulses issued in the current or last run.

Behaviour:
- Reset (asynchronous, reset=0):
  - State goes to IDLE; io_en_a=0; busy=0; done=0; deadlock=0; mutex_err=0; step_count=0; ptr=0.
  - Reset in mid-run aborts the run at once; no pulse is completed.
- Fireable(i):
  - True when state(i) is I, C or E.
  - True when state(i)=T and x_flag=1.
  - False when state(i)=T and x_flag=0.
- FSM has states IDLE, SELECT, ISSUE, CHECK, FINISH, HALT.
- IDLE:
  - busy=0.
  - On start: latch step_limit, clear step_count, deadlock and mutex_err, then go to SELECT.
  - If the latched limit is 0: go to FINISH instead.
- SELECT:
  - Search from ptr upward, mod N, for the first fireable node k.
  - If k is found: register io_en_a=(1<<k) and go to ISSUE.
  - If none is found: set deadlock and go to HALT.
- ISSUE:
  - io_en_a is high for exactly this one cycle.
  - Set ptr=(k+1) mod N and increment step_count.
  - Go to CHECK; io_en_a returns to 0 on the next cycle.
- CHECK:
  - Sample n_state and x_flag, which the model updated on the ISSUE edge.
  - Invariant: the number of nodes in C or E is at most 1; and if that number is 1, x_flag=0.
  - On violation: set mutex_err and go to HALT.
  - Otherwise: go to FINISH if step_count == latched limit, else go to SELECT.
- Step cadence is 3 cycles per pulse (SELECT, ISSUE, CHECK). There is never a pulse on two consecutive cycles.
- FINISH: pulse done=1 for one cycle, then go to IDLE.
- HALT: busy=0 and done is not pulsed. Leave HALT only on start, which clears the sticky flags and behaves as start from IDLE.
- busy=1 in SELECT, ISSUE, CHECK and FINISH.
- ptr persists across runs; it is cleared only by reset.
- step_count holds its value after a run and is cleared on the next start.
- When step_count reaches 2^CNT_W-1 with the limit not yet reached: finish as if the limit was met. The counter never wraps.
- start arriving while busy is ignored.
- Flattened n_state with N=1 is legal; the pointer is then always 0.

Test Plan:
- Normal run: N=3, model reset to all I with x=1; start with step_limit=5. Required: io_en_a sequence 001, 010, 100, 001, 010, each pulse 3 cycles apart; done pulses once; step_count=5; mutex_err=0.
- Skip unfireable node: n_state = {I,T,T} (node0=T, node1=T, node2=I) with x=0 held, ptr=0, step_limit=1. Required: io_en_a=100; ptr becomes 0.
- Deadlock: all nodes in T with x=0; start with step_limit=4. Required: deadlock=1, busy=0, done never asserted, io_en_a stays 0, step_count=0.
- Invariant error: after the first pulse, force n_state so that node0=C and node1=E. Required: mutex_err=1 in the cycle after CHECK; FSM in HALT; no further pulses.
- Zero limit, then mid-run reset:
  - start with step_limit=0 → done one cycle later and no pulses.
  - Start a run of 10 and assert reset low during ISSUE → io_en_a=0 immediately; all outputs at reset values; ptr=0.
- Start ignored while busy: pulse start again during a run with step_limit=2. Required: the run finishes after 2 pulses; the second start has no effect.
